// File: rtl/alu_pkg.sv
// Shared ALU definitions: serial add/sub FSM states,
// operation encodings and default datapath width.
package alu_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 6;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell.
// Port order (Cout, Sum, A, B, Cin).
module full_adder (
  output logic Cout,
  output logic Sum,
  input  logic A,
  input  logic B,
  input  logic Cin
);

  // Sum and carry-out for one bit position
  always_comb begin
    Sum  = A ^ B ^ Cin;
    Cout = (A & B) | (A & Cin) | (B & Cin);
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one full_adder
// cell time-shared over WIDTH cycles, LSB first.
module serial_add_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic             clear,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] LAST_BIT =
    CNT_W'(WIDTH - 1);

  state_t             r_state;
  logic [WIDTH-1:0]   r_opa;
  logic [WIDTH-1:0]   r_opb;
  logic [WIDTH-1:0]   r_sum;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_carry;
  logic               r_busy;
  logic               r_done;
  logic               r_cout;
  logic               r_ovf;

  logic               w_fa_sum;
  logic               w_fa_cout;

  full_adder u_fa (
    w_fa_cout,
    w_fa_sum,
    r_opa[0],
    r_opb[0],
    r_carry
  );

  // FSM, bit counter and shift-register datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_opa   <= '0;
      r_opb   <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (clear) begin
      // abort wins over start; data left partial
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_opa   <= a;
            r_opb   <= (op_sub == OP_SUB) ? ~b : b;
            r_carry <= op_sub;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_sum   <= {w_fa_sum, r_sum[WIDTH-1:1]};
          r_opa   <= r_opa >> 1;
          r_opb   <= r_opb >> 1;
          r_carry <= w_fa_cout;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_BIT) begin
            // r_carry is the carry into the MSB here
            r_cout  <= w_fa_cout;
            r_ovf   <= r_carry ^ w_fa_cout;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign sum      = r_sum;
  assign cout     = r_cout;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random checks for the bit-serial
// add/subtract controller at WIDTH=32.
module tb_serial_add_ctrl;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         op_sub;
  logic         clear;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  int n_pass;
  int n_total;

  serial_add_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op_sub   (op_sub),
    .clear    (clear),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: a + (sub ? ~b : b) + sub, 33 bits
  function automatic logic [W+1:0] ref_op(
    input logic [W-1:0] ra,
    input logic [W-1:0] rb,
    input logic         rs
  );
    logic [W-1:0] bb;
    logic [W:0]   full;
    logic         ov;
    bb   = rs ? ~rb : rb;
    full = {1'b0, ra} + {1'b0, bb} + {{W{1'b0}}, rs};
    ov   = (ra[W-1] == bb[W-1]) &&
           (full[W-1] != ra[W-1]);
    return {ov, full};
  endfunction

  // Runs one op from IDLE, checks result and timing
  task automatic do_op(
    input logic [W-1:0] ia,
    input logic [W-1:0] ib,
    input logic         isub,
    input logic [W-1:0] esum,
    input logic         ecout,
    input logic         eovf,
    input bit           disturb,
    input string        nm
  );
    int           done_cnt;
    int           done_at;
    int           busy_bad;
    logic [W-1:0] s_sum;
    logic         s_cout;
    logic         s_ovf;
    done_cnt = 0;
    done_at  = -1;
    busy_bad = 0;
    s_sum    = '0;
    s_cout   = 1'b0;
    s_ovf    = 1'b0;
    a = ia; b = ib; op_sub = isub; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= W + 2; n++) begin
      if (disturb && (n == 3 || n == 20)) begin
        start  = 1'b1;
        a      = ~ia;
        b      = ia ^ ib ^ 32'h5A5A_0F0F;
        op_sub = ~isub;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin
        done_cnt++;
        done_at = n;
      end
      if (busy !== (n < W)) busy_bad++;
      if (n == W) begin
        s_sum  = sum;
        s_cout = cout;
        s_ovf  = overflow;
      end
    end
    start = 1'b0;
    n_total++;
    if (s_sum !== esum)
      $display("FAIL %s sum got %h want %h",
               nm, s_sum, esum);
    else n_pass++;
    n_total++;
    if (s_cout !== ecout)
      $display("FAIL %s cout got %b want %b",
               nm, s_cout, ecout);
    else n_pass++;
    n_total++;
    if (s_ovf !== eovf)
      $display("FAIL %s overflow got %b want %b",
               nm, s_ovf, eovf);
    else n_pass++;
    n_total++;
    if (done_cnt !== 1 || done_at !== W)
      $display("FAIL %s done count %0d at %0d want 1 at %0d",
               nm, done_cnt, done_at, W);
    else n_pass++;
    n_total++;
    if (busy_bad !== 0)
      $display("FAIL %s busy wrong in %0d cycles want 0",
               nm, busy_bad);
    else n_pass++;
    n_total++;
    if ({sum, cout, overflow} !== {esum, ecout, eovf})
      $display("FAIL %s hold got %h/%b/%b want %h/%b/%b",
               nm, sum, cout, overflow, esum, ecout, eovf);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; clear = 1'b0;
    op_sub = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if ({busy, done, cout, overflow, sum} !== '0)
      $display("FAIL reset outputs got %b%b%b%b %h want 0",
               busy, done, cout, overflow, sum);
    else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_total++;
    if ({busy, done} !== 2'b00)
      $display("FAIL reset idle busy/done got %b%b want 00",
               busy, done);
    else n_pass++;
  endtask

  task automatic test_add();
    do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0,
          32'h0000_0000, 1'b1, 1'b0, 0, "add_wrap");
    do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0,
          32'h8000_0000, 1'b0, 1'b1, 0, "add_ovf");
  endtask

  task automatic test_sub();
    do_op(32'h0000_0005, 32'h0000_0007, 1'b1,
          32'hFFFF_FFFE, 1'b0, 1'b0, 0, "sub_borrow");
    do_op(32'h8000_0000, 32'h0000_0001, 1'b1,
          32'h7FFF_FFFF, 1'b1, 1'b1, 0, "sub_ovf");
  endtask

  task automatic test_ignore_start();
    do_op(32'h1234_5678, 32'h1111_1111, 1'b0,
          32'h2345_6789, 1'b0, 1'b0, 1, "mid_start");
  endtask

  task automatic test_abort_reset();
    int done_cnt;
    done_cnt = 0;
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    op_sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({busy, done, cout, overflow, sum} !== '0)
      $display("FAIL abort_rst outputs got %b%b%b%b %h want 0",
               busy, done, cout, overflow, sum);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < W + 2; n++) begin
      @(posedge clk); #1;
      if (done || busy) done_cnt++;
    end
    n_total++;
    if (done_cnt !== 0)
      $display("FAIL abort_rst activity %0d cycles want 0",
               done_cnt);
    else n_pass++;
  endtask

  task automatic test_abort_clear();
    int act;
    act = 0;
    a = 32'h0F0F_0F0F; b = 32'h0101_0101;
    op_sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    n_total++;
    if (busy !== 1'b1)
      $display("FAIL abort_clr busy pre got %b want 1", busy);
    else n_pass++;
    clear = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; start = 1'b0;
    n_total++;
    if ({busy, done} !== 2'b00)
      $display("FAIL abort_clr busy/done got %b%b want 00",
               busy, done);
    else n_pass++;
    for (int n = 0; n < W + 2; n++) begin
      @(posedge clk); #1;
      if (done || busy) act++;
    end
    n_total++;
    if (act !== 0)
      $display("FAIL abort_clr activity %0d cycles want 0", act);
    else n_pass++;
    do_op(32'h0000_1234, 32'h0000_4321, 1'b0,
          32'h0000_5555, 1'b0, 1'b0, 0, "after_clr");
  endtask

  task automatic test_random();
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rs;
    logic [W+1:0] r;
    for (int i = 0; i < 500; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      r  = ref_op(ra, rb, rs);
      do_op(ra, rb, rs, r[W-1:0], r[W], r[W+1],
            (i % 50) == 7, "random");
    end
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_add();
    test_sub();
    test_ignore_start();
    test_abort_reset();
    test_abort_clear();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
